// File: rtl/word_serializer.sv
// Serial transmitter for the 33-bit datapath word (32 data bits + flag in bit 32).
// Frame: start bit, 33 data bits LSB first, parity bit, stop bit; line idles high.
module word_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [32:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx_line,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [32:0] shreg;
  logic        parity_bit;
  logic [15:0] clk_cnt;
  logic [5:0]  bit_cnt;
  logic        bit_end;

  assign bit_end = (clk_cnt == LAST_TICK);

  // Every output is registered; tx_line is set one edge ahead so each bit
  // becomes visible exactly on the cycle after its transition edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      parity_bit <= 1'b0;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      tx_line    <= 1'b1;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg      <= in_word;
            parity_bit <= (^in_word) ^ PARITY_ODD;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            tx_line    <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx_line <= shreg[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 6'd32) begin
              tx_line <= parity_bit;
              state   <= PARITY;
            end else begin
              shreg   <= shreg >> 1;
              tx_line <= shreg[1];
              bit_cnt <= bit_cnt + 6'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            tx_line <= 1'b1;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          tx_line  <= 1'b1;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/word_serializer.md
# word_serializer

Transmit-side serial link for the CPU's 33-bit datapath word: 32 data bits plus a flag bit in bit 32. Accepts one parallel word per valid/ready handshake and sends it on a single-wire serial line. Frame is a start bit, 33 data bits LSB first, a parity bit, and a stop bit. Sits between the core's debug/IO port and an off-chip or on-chip deserializer, which is the matching receiver.

## Interface
- CLKS_PER_BIT, default 4: clock cycles each serial bit is held. Legal range 1..65535.
- PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity, computed over the 33 data bits.
- clk  input  1  rising-edge clock. One clock domain; reset is asynchronous and active-high.
- rst  input  1  asynchronous, active-high reset.
- in_word  input  33  parallel word to send. Sampled only on the accept edge.
- in_valid  input  1  word available.
- in_ready  output  1  block can accept a word. A word is accepted on a rising edge where in_valid and in_ready are both 1.
- tx_line  output  1  serial output. Idles high. Driven from a register, so it is glitch-free.
- busy  output  1  a frame is in progress (state is not IDLE).
- done  output  1  one-cycle pulse when a frame completes.

## Operation
- Reset values: tx_line=1, in_ready=1, busy=0, done=0, state=IDLE, bit and clock counters=0.
- States:
  - IDLE: in_ready=1. On accept, load in_word into the 33-bit shift register, compute the parity bit, and go to START.
  - START: tx_line=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_line=shreg[0]. After each CLKS_PER_BIT cycles, shift right and increment the bit counter (0..32). After bit 32, go to PARITY.
  - PARITY: tx_line=parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_line=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse done.
- Parity bit = ^in_word XOR PARITY_ODD, latched at the accept edge.
- Clock divider counts from 0 to CLKS_PER_BIT-1. It wraps to 0 on every bit boundary and is reset to 0 on accept.
- in_word and in_valid are ignored outside IDLE. A valid held high during a frame is not accepted until ready returns.
- in_ready is a registered output and equals (state==IDLE).
- Reset mid-frame: all outputs return to their reset values asynchronously. tx_line goes high immediately. The partial frame is abandoned and no done pulse is produced.

## Timing
- Accept at edge E. tx_line falls at E (registered), so the start bit is visible in cycle E+1.
- Data bit n occupies cycles E+1+(n+1)·CLKS_PER_BIT through E+(n+2)·CLKS_PER_BIT.
- A frame is 36·CLKS_PER_BIT cycles. IDLE is re-entered, with done=1 and in_ready=1, in cycle E+1+36·CLKS_PER_BIT.
- done is high for exactly one cycle.
- Back-to-back words: the next accept is allowed at the edge ending the first IDLE cycle. The line therefore stays high for CLKS_PER_BIT+1 cycles between frames, which is the minimum gap.
- busy falls in the same cycle that in_ready rises.
- CLKS_PER_BIT=1 must work: one bit per cycle and a 36-cycle frame.

## Test plan
- Reset, then idle for 20 cycles -> tx_line=1, in_ready=1, busy=0, done never asserted.
- CLKS_PER_BIT=4, PARITY_ODD=0, in_word=33'h1_0000_0001 -> sampled bits: start 0; data 1, then 31 zeros, then 1; parity 0; stop 1. done fires 145 cycles after accept.
- Same word with PARITY_ODD=1 -> parity bit 1. Word 33'h0_0000_0007 with even parity -> parity bit 1.
- Hold in_valid high across 3 words (33'h0_DEADBEEF, 33'h1_12345678, 33'h0_00000000), each changing only on accept -> three correct frames in order. Each gap has the line high for exactly CLKS_PER_BIT+1 cycles, and no word is dropped or duplicated.
- Change in_word mid-frame while in_valid=0 -> the transmitted frame still matches the word latched at accept.
- Assert rst during data bit 10 -> tx_line=1 in the same cycle, in_ready=1 after release, no done pulse. The next word then transmits correctly.
